// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end.
// Issues sequential word fetches over a req/gnt + rvalid memory port. Returned
// words go into a small in-order FIFO that feeds the control unit. A redirect
// flushes the FIFO and kills wrong-path responses that are still in flight.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// raises a sticky misalign_err and stops all fetching until reset. Without the
// macro, the low two target bits are dropped and misalign_err is tied low.
//
// Handshakes: imem_req/imem_addr hold steady until imem_gnt is seen high on a
// rising edge. inst/pc/inst_valid hold until inst_ready is seen with
// inst_valid, which is a pop. A pop with pcmux_sel set is a redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcmux_sel,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {REQ_IDLE = 1'b0, REQ_WAIT = 1'b1} req_state_e;

  req_state_e        state_q;
  logic              req_q;
  logic [31:0]       addr_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic              stale_q, stale_d;
  logic              halt_q, halt_d;

  logic              pop, redirect, gnt_fire, push, credit, misalign_hit;
  logic [31:0]       target;
  logic              unused_bits;

  // Low target bits are only inspected by the trap build.
  assign unused_bits = ^alu_out[1:0];

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst       = data_mem_q[rd_ptr_q];
  assign pc         = pc_mem_q[rd_ptr_q];
  assign inst_valid = (cnt_q != '0);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_hit = redirect & (alu_out[1:0] != 2'b00);
  assign misalign_err = misalign_q;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            misalign_q <= 1'b0;
    else if (misalign_hit) misalign_q <= 1'b1;
  end
`else
  assign misalign_hit = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Next-state for counters, pointers, addresses and the stale/kill tracking.
  always_comb begin
    pop      = inst_valid & inst_ready;
    redirect = pcmux_sel & pop;
    gnt_fire = req_q & imem_gnt;
    target   = {alu_out[31:2], 2'b00};
    // A response arriving with a redirect is wrong-path: never buffered.
    push     = imem_rvalid & (kill_q == '0) & ~redirect;

    out_d = out_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);

    kill_d = kill_q;
    if (imem_rvalid && kill_q != '0) kill_d = kill_d - 1'b1;
    if (gnt_fire && stale_q)         kill_d = kill_d + 1'b1;
    if (redirect)                    kill_d = out_d;

    // A request pending at redirect keeps its address; remember to kill it.
    stale_d = stale_q;
    if (gnt_fire)                         stale_d = 1'b0;
    if (redirect && req_q && !imem_gnt)   stale_d = 1'b1;

    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (redirect) begin
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect)                  fetch_pc_d = target;
    else if (gnt_fire && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;

    resp_pc_d = resp_pc_q;
    if (redirect)  resp_pc_d = target;
    else if (push) resp_pc_d = resp_pc_q + 32'd4;

    halt_d = halt_q | misalign_hit;
    credit = ({1'b0, out_d} + {1'b0, cnt_d}) < DEPTH_C;
  end

  // Request FSM with registered imem_req/imem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else if (halt_d) begin
      state_q <= REQ_IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        REQ_IDLE: begin
          if (credit) begin
            state_q <= REQ_WAIT;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_d;
          end
        end
        REQ_WAIT: begin
          if (gnt_fire) begin
            if (credit) begin
              addr_q <= fetch_pc_d;
            end else begin
              state_q <= REQ_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= REQ_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Counters, pointers and address tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      kill_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      stale_q    <= stale_d;
      halt_q     <= halt_d;
    end
  end

  // FIFO storage: reset so the head reads inst=0, pc=RESET_PC out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= RESET_PC;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcmux_sel = 1'b0;
  logic [31:0] alu_out = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] grant_q[$];
  logic [63:0] pop_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] hold_addr = '0;
  int          hold_left = 0;
  bit          redir_fired = 1'b0;
  bit          mem_last_gnt = 1'b0;
  logic [31:0] mem_last_addr = '0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .pcmux_sel(pcmux_sel), .alu_out(alu_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .misalign_err(misalign_err)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Memory model: grants on request (unless holding), responds one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; mem_last_gnt = 1'b0;
      end else begin
        imem_rvalid = mem_last_gnt;
        imem_rdata  = word_of(mem_last_addr);
        mem_last_gnt = 1'b0;
        imem_gnt     = 1'b0;
        if (imem_req) begin
          if (hold_left > 0 && imem_addr == hold_addr) hold_left--;
          else begin
            imem_gnt = 1'b1; mem_last_gnt = 1'b1; mem_last_addr = imem_addr;
          end
        end
      end
    end
  end

  // Monitor: logs granted addresses and popped {pc, inst}.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (imem_req && imem_gnt) grant_q.push_back(imem_addr);
        if (inst_valid && inst_ready) pop_q.push_back({pc, inst});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; pcmux_sel = 1'b0; alu_out = '0; inst_ready = 1'b1;
    hold_left = 0; redir_fired = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    grant_q.delete(); pop_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n, input bit use_trig,
                            input logic [31:0] trig_pc, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      pcmux_sel = 1'b0;
      if (use_trig && !redir_fired && inst_valid && inst_ready && pc == trig_pc) begin
        pcmux_sel = 1'b1; alu_out = tgt; redir_fired = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b need 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h need %h", imem_addr, RESET_PC); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h need 0", inst); end
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h need %h", pc, RESET_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", inst_valid); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b need 0", misalign_err); end
  endtask

  task automatic test_sequential();
    do_reset();
    run_cycles(20, 1'b0, '0, '0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    checks++;
    if (grant_q.size() < exp_q.size()) begin errors++; $display("FAIL seq_grant_count: got %0d need >=4", grant_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (grant_q[i] !== exp_q[i]) begin errors++; $display("FAIL seq_grant[%0d]: got %h need %h", i, grant_q[i], exp_q[i]); end
    end
    checks++;
    if (pop_q.size() < exp_q.size()) begin errors++; $display("FAIL seq_pop_count: got %0d need >=4", pop_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (pop_q[i] !== {exp_q[i], word_of(exp_q[i])}) begin
        errors++; $display("FAIL seq_pop[%0d]: got pc=%h inst=%h need pc=%h inst=%h", i, pop_q[i][63:32], pop_q[i][31:0], exp_q[i], word_of(exp_q[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    run_cycles(8, 1'b0, '0, '0);
    checks++; if (grant_q.size() != 2) begin errors++; $display("FAIL bp_grant_count: got %0d need 2", grant_q.size()); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b need 0", imem_req); end
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h13) begin
      errors++; $display("FAIL bp_head: got v=%b pc=%h inst=%h need v=1 pc=0 inst=00000013", inst_valid, pc, inst);
    end
    inst_ready = 1'b1;
    run_cycles(12, 1'b0, '0, '0);
    exp_q = '{32'h0, 32'h4, 32'h8};
    checks++;
    if (pop_q.size() < 3 || grant_q.size() < 3) begin errors++; $display("FAIL bp_resume_count: got pops=%0d grants=%0d need >=3", pop_q.size(), grant_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++;
        if (pop_q[i] !== {exp_q[i], word_of(exp_q[i])}) begin errors++; $display("FAIL bp_pop[%0d]: got pc=%h need pc=%h", i, pop_q[i][63:32], exp_q[i]); end
      end
      checks++; if (grant_q[2] !== 32'h8) begin errors++; $display("FAIL bp_resume_addr: got %h need 00000008", grant_q[2]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run_cycles(20, 1'b1, 32'h8, 32'h100);
    checks++; if (!redir_fired) begin errors++; $display("FAIL redir_fired: got 0 need 1"); end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};
    checks++;
    if (grant_q.size() < 5) begin errors++; $display("FAIL redir_grant_count: got %0d need >=5", grant_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (grant_q[i] !== exp_q[i]) begin errors++; $display("FAIL redir_grant[%0d]: got %h need %h", i, grant_q[i], exp_q[i]); end
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    checks++;
    if (pop_q.size() < 5) begin errors++; $display("FAIL redir_pop_count: got %0d need >=5", pop_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (pop_q[i] !== {exp_q[i], word_of(exp_q[i])}) begin errors++; $display("FAIL redir_pop[%0d]: got pc=%h need pc=%h", i, pop_q[i][63:32], exp_q[i]); end
    end
  endtask

  task automatic test_redirect_during_wait();
    bit fired = 1'b0;
    bit granted = 1'b0;
    do_reset();
    hold_addr = 32'h10; hold_left = 3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      pcmux_sel = 1'b0;
      if (fired && !granted && imem_req) begin
        checks++;
        if (imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr_hold: got %h need 00000010", imem_addr); end
        if (imem_gnt) granted = 1'b1;
      end
      if (!fired && inst_valid && pc == 32'hC && imem_req && !imem_gnt) begin
        pcmux_sel = 1'b1; alu_out = 32'h40; fired = 1'b1;
      end
    end
    checks++; if (!fired || !granted) begin errors++; $display("FAIL wait_redirect_seen: got fired=%b granted=%b need 1 1", fired, granted); end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40};
    checks++;
    if (grant_q.size() < 6) begin errors++; $display("FAIL wait_grant_count: got %0d need >=6", grant_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (grant_q[i] !== exp_q[i]) begin errors++; $display("FAIL wait_grant[%0d]: got %h need %h", i, grant_q[i], exp_q[i]); end
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40};
    checks++;
    if (pop_q.size() < 5) begin errors++; $display("FAIL wait_pop_count: got %0d need >=5", pop_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (pop_q[i] !== {exp_q[i], word_of(exp_q[i])}) begin errors++; $display("FAIL wait_pop[%0d]: got pc=%h need pc=%h", i, pop_q[i][63:32], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    inst_ready = 1'b0;
    run_cycles(3, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %b need 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL mid_reset_addr: got %h need %h", imem_addr, RESET_PC); end
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || pc !== RESET_PC) begin
      errors++; $display("FAIL mid_reset_head: got v=%b inst=%h pc=%h need v=0 inst=0 pc=%h", inst_valid, inst, pc, RESET_PC);
    end
    @(negedge clk); #1;
    grant_q.delete(); pop_q.delete();
    inst_ready = 1'b1;
    rst_n = 1'b1;
    run_cycles(10, 1'b0, '0, '0);
    checks++;
    if (grant_q.size() < 2 || pop_q.size() < 1) begin errors++; $display("FAIL mid_restart_count: got grants=%0d pops=%0d need >=2 >=1", grant_q.size(), pop_q.size()); end
    else begin
      checks++; if (grant_q[0] !== RESET_PC) begin errors++; $display("FAIL mid_restart_addr0: got %h need %h", grant_q[0], RESET_PC); end
      checks++; if (grant_q[1] !== RESET_PC + 32'd4) begin errors++; $display("FAIL mid_restart_addr1: got %h need %h", grant_q[1], RESET_PC + 32'd4); end
      checks++; if (pop_q[0] !== {RESET_PC, word_of(RESET_PC)}) begin errors++; $display("FAIL mid_restart_pop: got pc=%h inst=%h", pop_q[0][63:32], pop_q[0][31:0]); end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    run_cycles(20, 1'b1, 32'h8, 32'h102);
    checks++; if (!redir_fired) begin errors++; $display("FAIL mis_fired: got 0 need 1"); end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b need 1", misalign_err); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req_low: got %b need 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b need 0", inst_valid); end
    checks++; if (grant_q.size() != 4) begin errors++; $display("FAIL mis_grant_count: got %0d need 4", grant_q.size()); end
    checks++; if (pop_q.size() != 3) begin errors++; $display("FAIL mis_pop_count: got %0d need 3", pop_q.size()); end
`else
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b need 0", misalign_err); end
    checks++;
    if (grant_q.size() < 5 || pop_q.size() < 4) begin errors++; $display("FAIL mis_count: got grants=%0d pops=%0d need >=5 >=4", grant_q.size(), pop_q.size()); end
    else begin
      checks++; if (grant_q[4] !== 32'h100) begin errors++; $display("FAIL mis_next_addr: got %h need 00000100", grant_q[4]); end
      checks++; if (pop_q[3] !== {32'h100, word_of(32'h100)}) begin errors++; $display("FAIL mis_next_pop: got pc=%h need pc=00000100", pop_q[3][63:32]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_during_wait();
    test_reset_midflight();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
